// File: rtl/sram_controller.sv
// Memory-stage SRAM controller: each 32-bit load/store becomes two 16-bit SRAM
// accesses (low half then high half), each phase held WAIT_CYCLES+1 cycles.
module sram_controller #(
   parameter int unsigned BASE_ADDR   = 1024,
   parameter int unsigned SRAM_AW     = 18,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               rd_en,
   input  logic               wr_en,
   input  logic [31:0]        address,
   input  logic [31:0]        write_data,
   output logic [31:0]        read_data,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [15:0]        sram_dq_out,
   output logic               sram_dq_oe,
   input  logic [15:0]        sram_dq_in,
   output logic               sram_we_n
);

   localparam logic [3:0] LP_WAIT = 4'(WAIT_CYCLES);

   typedef enum logic [1:0] {S_IDLE, S_LO, S_HI, S_DONE} state_t;

   state_t             r_state;
   logic [SRAM_AW-2:0] r_word;
   logic [31:0]        r_data;
   logic               r_wr;
   logic [3:0]         r_wait;
   logic [31:0]        r_read_data;
   logic [SRAM_AW-1:0] r_sram_addr;
   logic [15:0]        r_sram_dq_out;
   logic               r_sram_dq_oe;
   logic               r_sram_we_n;

   logic               w_req;
   logic               w_last;
   logic [31:0]        w_offset;
   logic [SRAM_AW-2:0] w_word;
   logic               w_unused;

   assign w_req    = rd_en | wr_en;
   assign w_last   = (r_wait == LP_WAIT);
   assign w_offset = address - BASE_ADDR;
   assign w_word   = w_offset[SRAM_AW:2];
   // Offset bits above the SRAM window are dropped, so out-of-range addresses wrap.
   assign w_unused = &{1'b0, w_offset[31:SRAM_AW+1], w_offset[1:0]};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state       <= S_IDLE;
         r_word        <= '0;
         r_data        <= '0;
         r_wr          <= 1'b0;
         r_wait        <= '0;
         r_read_data   <= '0;
         r_sram_addr   <= '0;
         r_sram_dq_out <= '0;
         r_sram_dq_oe  <= 1'b0;
         r_sram_we_n   <= 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (w_req) begin
                  r_wr        <= wr_en;
                  r_word      <= w_word;
                  r_data      <= write_data;
                  r_wait      <= '0;
                  r_sram_addr <= {w_word, 1'b0};
                  if (wr_en) begin
                     r_sram_dq_out <= write_data[15:0];
                     r_sram_dq_oe  <= 1'b1;
                     r_sram_we_n   <= 1'b0;
                  end
                  r_state <= S_LO;
               end
            end
            S_LO: begin
               if (w_last) begin
                  r_wait      <= '0;
                  r_sram_addr <= {r_word, 1'b1};
                  if (r_wr) r_sram_dq_out <= r_data[31:16];
                  else      r_read_data[15:0] <= sram_dq_in;
                  r_state <= S_HI;
               end else begin
                  r_wait <= r_wait + 4'd1;
               end
            end
            S_HI: begin
               if (w_last) begin
                  r_wait       <= '0;
                  r_sram_dq_oe <= 1'b0;
                  r_sram_we_n  <= 1'b1;
                  if (!r_wr) r_read_data[31:16] <= sram_dq_in;
                  r_state <= S_DONE;
               end else begin
                  r_wait <= r_wait + 4'd1;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign ready       = ((r_state == S_IDLE) && !w_req) || (r_state == S_DONE);
   assign read_data   = r_read_data;
   assign sram_addr   = r_sram_addr;
   assign sram_dq_out = r_sram_dq_out;
   assign sram_dq_oe  = r_sram_dq_oe;
   assign sram_we_n   = r_sram_we_n;

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: two instances (WAIT_CYCLES 0 and 1), a small SRAM
// emulation each, and a cycle-position model compared on every falling edge.
module tb_sram_controller;

   localparam logic [31:0] BASE = 32'd1024;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        rd_en [2];
   logic        wr_en [2];
   logic [31:0] address [2];
   logic [31:0] write_data [2];
   logic [31:0] read_data [2];
   logic        ready [2];
   logic [17:0] sram_addr [2];
   logic [15:0] dq_out [2];
   logic [15:0] dq_in [2];
   logic        dq_oe [2];
   logic        we_n [2];
   logic [15:0] mem [2][64];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always #5 clk = ~clk;

   sram_controller #(.BASE_ADDR(1024), .SRAM_AW(18), .WAIT_CYCLES(0)) u_dut0 (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en[0]), .wr_en(wr_en[0]),
      .address(address[0]), .write_data(write_data[0]), .read_data(read_data[0]),
      .ready(ready[0]), .sram_addr(sram_addr[0]), .sram_dq_out(dq_out[0]),
      .sram_dq_oe(dq_oe[0]), .sram_dq_in(dq_in[0]), .sram_we_n(we_n[0])
   );

   sram_controller #(.BASE_ADDR(1024), .SRAM_AW(18), .WAIT_CYCLES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .rd_en(rd_en[1]), .wr_en(wr_en[1]),
      .address(address[1]), .write_data(write_data[1]), .read_data(read_data[1]),
      .ready(ready[1]), .sram_addr(sram_addr[1]), .sram_dq_out(dq_out[1]),
      .sram_dq_oe(dq_oe[1]), .sram_dq_in(dq_in[1]), .sram_we_n(we_n[1])
   );

   assign dq_in[0] = mem[0][sram_addr[0][5:0]];
   assign dq_in[1] = mem[1][sram_addr[1][5:0]];
   wire tb_unused_bits = ^{sram_addr[0][17:6], sram_addr[1][17:6]};

   task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s inst=%0d cyc=%0d actual=%h expected=%h", nm, i, cyc, act, exp);
      end
   endtask

   // Model: p = cycles since acceptance (0 = idle); LO is p in 1..W+1, HI in W+2..2W+2, DONE at 2W+3.
   int          mw [2] = '{0, 1};
   int          p [2] = '{0, 0};
   bit          mwr [2];
   int          mword [2];
   logic [31:0] mdata [2];
   logic [31:0] mrd [2];
   logic [17:0] maddr [2];
   logic [15:0] mdq [2];
   bit          mvalid = 1'b0;

   initial begin
      int          w;
      bit          req, lo, hi, done;
      logic [17:0] ea;
      logic [15:0] ed;
      logic [31:0] off;
      forever begin
         @(negedge clk);
         cyc++;
         for (int i = 0; i < 2; i++) begin
            w    = mw[i];
            req  = rd_en[i] | wr_en[i];
            lo   = (p[i] >= 1) && (p[i] <= w + 1);
            hi   = (p[i] >= w + 2) && (p[i] <= 2 * w + 2);
            done = (p[i] == 2 * w + 3);
            ea = lo ? 18'(mword[i] * 2) : hi ? 18'(mword[i] * 2 + 1) : maddr[i];
            ed = (mwr[i] && lo) ? mdata[i][15:0] : (mwr[i] && hi) ? mdata[i][31:16] : mdq[i];
            if (mvalid) begin
               chk("ready", i, 32'(ready[i]), 32'(((p[i] == 0) && !req) || done));
               chk("we_n", i, 32'(we_n[i]), 32'(!(mwr[i] && (lo || hi))));
               chk("dq_oe", i, 32'(dq_oe[i]), 32'(mwr[i] && (lo || hi)));
               chk("sram_addr", i, 32'(sram_addr[i]), 32'(ea));
               chk("dq_out", i, 32'(dq_out[i]), 32'(ed));
               chk("read_data", i, read_data[i], mrd[i]);
            end
            maddr[i] = ea;
            mdq[i]   = ed;
            if (we_n[i] === 1'b0) mem[i][sram_addr[i][5:0]] = dq_out[i];
            if (!rst_n) begin
               p[i] = 0; mrd[i] = '0; maddr[i] = '0; mdq[i] = '0;
            end else if (p[i] == 0) begin
               if (req) begin
                  off      = address[i] - BASE;
                  mwr[i]   = wr_en[i];
                  mword[i] = int'(off[18:2]);
                  mdata[i] = write_data[i];
                  p[i]     = 1;
               end
            end else if (done) begin
               p[i] = 0;
            end else begin
               if (!mwr[i] && p[i] == w + 1)     mrd[i][15:0]  = mem[i][(mword[i] * 2) % 64];
               if (!mwr[i] && p[i] == 2 * w + 2) mrd[i][31:16] = mem[i][(mword[i] * 2 + 1) % 64];
               p[i]++;
            end
         end
         if (!rst_n) mvalid = 1'b1;
      end
   end

   task automatic wait_ready(input int i, output int low);
      low = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (ready[i]) break;
         low++;
      end
   endtask

   task automatic access(input int i, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, output int low);
      @(posedge clk); #1;
      rd_en[i] = rd; wr_en[i] = wr; address[i] = a; write_data[i] = d;
      wait_ready(i, low);
   endtask

   task automatic idle(input int i);
      @(posedge clk); #1;
      rd_en[i] = 1'b0; wr_en[i] = 1'b0;
   endtask

   initial begin
      int low;
      rst_n = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rd_en[i] = 1'b0; wr_en[i] = 1'b0; address[i] = '0; write_data[i] = '0;
         for (int j = 0; j < 64; j++) mem[i][j] = '0;
      end
      mem[1][2] = 16'h5678; mem[1][3] = 16'h1234;
      mem[0][0] = 16'h1111; mem[0][1] = 16'h2222;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      chk("rst_read_data", 1, read_data[1], 32'h0);
      chk("rst_sram_addr", 1, 32'(sram_addr[1]), 32'h0);

      // Quiet bus while idle
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk("idle_ready", 1, 32'(ready[1]), 32'h1);
         chk("idle_we_n", 1, 32'(we_n[1]), 32'h1);
         chk("idle_oe", 1, 32'(dq_oe[1]), 32'h0);
      end

      access(1, 1'b0, 1'b1, 32'd1024, 32'hDEADBEEF, low);
      chk("t2_low_cycles", 1, 32'(low), 32'd5);
      idle(1);
      chk("t2_mem0", 1, 32'(mem[1][0]), 32'hBEEF);
      chk("t2_mem1", 1, 32'(mem[1][1]), 32'hDEAD);

      access(1, 1'b1, 1'b0, 32'd1028, 32'h0, low);
      chk("t3_low_cycles", 1, 32'(low), 32'd5);
      chk("t3_read_data", 1, read_data[1], 32'h12345678);
      idle(1);

      access(0, 1'b1, 1'b0, 32'd1024, 32'h0, low);
      chk("t4_rd_low", 0, 32'(low), 32'd3);
      chk("t4_read_data", 0, read_data[0], 32'h22221111);
      access(0, 1'b0, 1'b1, 32'd1032, 32'h89ABCDEF, low);
      chk("t4_wr_low", 0, 32'(low), 32'd3);
      idle(0);
      chk("t4_mem4", 0, 32'(mem[0][4]), 32'hCDEF);
      chk("t4_mem5", 0, 32'(mem[0][5]), 32'h89AB);

      access(1, 1'b1, 1'b1, 32'd1024, 32'h0000CAFE, low);
      chk("t6_low_cycles", 1, 32'(low), 32'd5);
      idle(1);
      chk("t6_read_data_kept", 1, read_data[1], 32'h12345678);
      chk("t6_mem0", 1, 32'(mem[1][0]), 32'hCAFE);
      chk("t6_mem1", 1, 32'(mem[1][1]), 32'h0000);

      // Reset lands in the first HI cycle of a write; request stays held
      @(posedge clk); #1;
      wr_en[1] = 1'b1; address[1] = 32'd1036; write_data[1] = 32'hA5A55A5A;
      repeat (3) begin @(posedge clk); #1; end
      chk("t5_hi_we_n", 1, 32'(we_n[1]), 32'h0);
      chk("t5_hi_addr", 1, 32'(sram_addr[1]), 32'd7);
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      chk("t5_rst_we_n", 1, 32'(we_n[1]), 32'h1);
      chk("t5_rst_oe", 1, 32'(dq_oe[1]), 32'h0);
      chk("t5_rst_read_data", 1, read_data[1], 32'h0);
      chk("t5_rst_ready", 1, 32'(ready[1]), 32'h0);
      wait_ready(1, low);
      chk("t5_restart_low", 1, 32'(low), 32'd5);
      idle(1);
      chk("t5_mem6", 1, 32'(mem[1][6]), 32'h5A5A);
      chk("t5_mem7", 1, 32'(mem[1][7]), 32'hA5A5);

      repeat (3) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout cyc=%0d", cyc);
      $fatal(1, "timeout");
   end

endmodule
